vfpu_result_collector: RTL and testbench

//  Issue-side partner of the vector FPU. It accepts issue requests (operands

---
 rtl/vfpu_pkg.sv | 16 +
 rtl/vfpu_wb_fifo.sv | 64 ++++++
 rtl/vfpu_result_collector.sv | 93 +++++++++
 tb/tb_vfpu_result_collector.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vfpu_pkg.sv
// Shared defaults and types for the vector FPU issue/write-back slice.
// Tag layout mirrors the destination register carried alongside each op.
package vfpu_pkg;

    localparam int VECTOR_LANES = 16;
    localparam int DATA_WIDTH   = 32;
    localparam int NUM_STAGES   = 3;
    localparam int ADDR_WIDTH   = 5;
    localparam int FIFO_DEPTH   = 2;

    typedef struct packed {
        logic                  v;
        logic [ADDR_WIDTH-1:0] addr;
    } vfpu_tag_t;

endpackage

// File: rtl/vfpu_wb_fifo.sv
// Small synchronous FIFO feeding the vector register-file write port.
// A push into a full FIFO is taken only when a pop frees a slot on the same edge.
module vfpu_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vfpu_result_collector.sv
// Issue-side partner of the vector FPU: tracks ops through the MAC pipe,
// captures results as their tags emerge and queues them for write-back.
module vfpu_result_collector #(
    parameter int VECTOR_LANES = vfpu_pkg::VECTOR_LANES,
    parameter int DATA_WIDTH   = vfpu_pkg::DATA_WIDTH,
    parameter int NUM_STAGES   = vfpu_pkg::NUM_STAGES,
    parameter int ADDR_WIDTH   = vfpu_pkg::ADDR_WIDTH,
    parameter int FIFO_DEPTH   = vfpu_pkg::FIFO_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 issue_valid,
    input  logic [ADDR_WIDTH-1:0]                issue_waddr,
    output logic                                 issue_ready,
    output logic                                 vfpu_en,
    input  logic [VECTOR_LANES*DATA_WIDTH-1:0]   vfpu_out,
    output logic                                 wb_valid,
    input  logic                                 wb_ready,
    output logic [ADDR_WIDTH-1:0]                wb_addr,
    output logic [VECTOR_LANES*DATA_WIDTH-1:0]   wb_data,
    output logic                                 busy
);

    import vfpu_pkg::*;

    localparam int DW = VECTOR_LANES * DATA_WIDTH;
    localparam int EW = ADDR_WIDTH + DW;
    localparam int CW = $clog2(FIFO_DEPTH+1);

    typedef struct packed {
        logic                  v;
        logic [ADDR_WIDTH-1:0] addr;
    } tag_t;

    tag_t          tag_q [NUM_STAGES];
    logic          adv;
    logic          push;
    logic          pop;
    logic          any_v;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [EW-1:0] fifo_dout;

    assign pop  = wb_valid && wb_ready;
    assign adv  = !tag_q[NUM_STAGES-1].v || !fifo_full || pop;
    assign push = adv && tag_q[NUM_STAGES-1].v;

    assign vfpu_en     = adv;
    assign issue_ready = adv;

    // Tags shift in lockstep with the FPU pipe so the last one owns vfpu_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                tag_q[k] <= '0;
            end
        end else if (adv) begin
            tag_q[0] <= '{v: issue_valid, addr: issue_waddr};
            for (int k = 1; k < NUM_STAGES; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    always_comb begin
        any_v = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            any_v = any_v | tag_q[k].v;
        end
    end

    vfpu_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({tag_q[NUM_STAGES-1].addr, vfpu_out}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign wb_valid = !fifo_empty;
    assign wb_addr  = fifo_dout[EW-1 -: ADDR_WIDTH];
    assign wb_data  = fifo_dout[DW-1:0];
    assign busy     = any_v || (fifo_count != '0);

endmodule

// File: tb/tb_vfpu_result_collector.sv
// Scoreboard bench for vfpu_result_collector with a behavioural FPU pipe.
module tb_vfpu_result_collector;

    localparam int LANES = 16;
    localparam int DWID  = 32;
    localparam int NS    = 3;
    localparam int AW    = 5;
    localparam int DW    = LANES * DWID;
    localparam int CMPW  = AW + DW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_waddr = '0;
    logic          issue_ready;
    logic          vfpu_en;
    logic [DW-1:0] vfpu_out;
    logic          wb_valid;
    logic          wb_ready = 1'b0;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          busy;

    logic [DW-1:0] op_data = '0;
    logic [DW-1:0] pipe [NS];
    exp_t          exp_q [$];
    int            pops [$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic          last_acc;

    vfpu_result_collector #(
        .VECTOR_LANES (LANES),
        .DATA_WIDTH   (DWID),
        .NUM_STAGES   (NS),
        .ADDR_WIDTH   (AW),
        .FIFO_DEPTH   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_waddr (issue_waddr),
        .issue_ready (issue_ready),
        .vfpu_en     (vfpu_en),
        .vfpu_out    (vfpu_out),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FPU: operands advance only while enabled.
    initial begin
        for (int k = 0; k < NS; k++) pipe[k] = '0;
    end

    always @(posedge clk) begin
        if (vfpu_en) begin
            pipe[0] <= op_data;
            for (int k = 1; k < NS; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign vfpu_out = pipe[NS-1];

    task automatic check(input string tag,
                         input logic [CMPW-1:0] got,
                         input logic [CMPW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", CMPW'(exp_q.size()), CMPW'(1));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_addr", CMPW'(wb_addr), CMPW'(e.addr));
                check("wb_data", CMPW'(wb_data), CMPW'(e.data));
                pops.push_back(cyc);
            end
        end
    end

    task automatic cycle(input logic v, input logic [AW-1:0] a,
                         input logic wr);
        @(negedge clk);
        issue_valid = v;
        issue_waddr = a;
        wb_ready    = wr;
        for (int l = 0; l < LANES; l++) op_data[l*DWID +: DWID] = $urandom;
        #1;
        last_acc = v && issue_ready;
        if (last_acc) exp_q.push_back('{addr: a, data: op_data});
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && busy; i++) cycle(1'b0, '0, 1'b1);
        check("drain_busy", CMPW'(busy), CMPW'(0));
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_wb_valid"}, CMPW'(wb_valid), CMPW'(0));
        check({pfx, "_busy"}, CMPW'(busy), CMPW'(0));
        check({pfx, "_en"}, CMPW'(vfpu_en), CMPW'(1));
        check({pfx, "_ready"}, CMPW'(issue_ready), CMPW'(1));
        check({pfx, "_wb_addr"}, CMPW'(wb_addr), CMPW'(0));
        check({pfx, "_wb_data"}, CMPW'(wb_data), CMPW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int bz;
        int snap;
        #12;
        check_reset_state("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        // Single op: visible exactly NS+1 cycles after issue.
        cycle(1'b1, 5'd5, 1'b1);
        for (int k = 1; k <= NS + 3; k++) begin
            cycle(1'b0, '0, 1'b1);
            check("single_vld", CMPW'(wb_valid), CMPW'(k == NS + 1));
            if (k == NS + 1) check("single_addr", CMPW'(wb_addr), CMPW'(5));
        end
        drain();

        // Back-to-back issue never stalls and write-backs are contiguous.
        pops.delete();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, AW'(i), 1'b1);
            check("b2b_en", CMPW'(vfpu_en), CMPW'(1));
        end
        drain();
        check("b2b_npop", CMPW'(pops.size()), CMPW'(4));
        if (pops.size() == 4)
            check("b2b_span", CMPW'(pops[3] - pops[0]), CMPW'(3));

        // Backpressure: FIFO full plus one result parked at the last tag.
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, AW'(10 + i), 1'b0);
            check("bp_acc", CMPW'(last_acc), CMPW'(1));
        end
        cycle(1'b1, 5'd16, 1'b0);
        check("bp_acc6", CMPW'(last_acc), CMPW'(0));
        check("bp_en", CMPW'(vfpu_en), CMPW'(0));
        check("bp_ready", CMPW'(issue_ready), CMPW'(0));
        check("bp_count", CMPW'(dut.u_fifo.count), CMPW'(2));
        check("bp_tagv", CMPW'(dut.tag_q[NS-1].v), CMPW'(1));
        check("bp_head", CMPW'(wb_addr), CMPW'(11));
        // Full FIFO with a pop frees the pipe on the same edge.
        cycle(1'b1, 5'd16, 1'b1);
        check("fp_en", CMPW'(vfpu_en), CMPW'(1));
        check("fp_acc", CMPW'(last_acc), CMPW'(1));
        cycle(1'b0, '0, 1'b1);
        check("fp_count", CMPW'(dut.u_fifo.count), CMPW'(2));
        drain();

        // Bubbles keep their spacing through to write-back.
        pops.delete();
        cycle(1'b1, 5'd1, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 5'd2, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 5'd3, 1'b1);
        bz = -1;
        for (int i = 0; i < 100 && busy; i++) begin
            cycle(1'b0, '0, 1'b1);
            if (!busy) bz = cyc;
        end
        check("bub_npop", CMPW'(pops.size()), CMPW'(3));
        if (pops.size() == 3) begin
            check("bub_gap1", CMPW'(pops[1] - pops[0]), CMPW'(2));
            check("bub_gap2", CMPW'(pops[2] - pops[1]), CMPW'(3));
            check("bub_idle", CMPW'(bz - pops[2]), CMPW'(1));
        end

        // Reset with two ops in flight drops them silently.
        cycle(1'b1, 5'd7, 1'b1);
        cycle(1'b1, 5'd8, 1'b1);
        @(negedge clk);
        issue_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst1");
        exp_q.delete();
        snap = pops.size();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
        check("rst1_nowb", CMPW'(pops.size()), CMPW'(snap));
        check("rst1_busy", CMPW'(busy), CMPW'(0));

        check("sb_empty", CMPW'(exp_q.size()), CMPW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
